// File: rtl/module_disp_enc_if.sv
// module_disp_enc_if: multiplexed segment-bus monitor port bundle.
// master drives the sampled display bus; slave is the monitor.
`default_nettype none

interface module_disp_enc_if #(
    parameter int NDIG = 4
);
    logic                sample_i;
    logic [6:0]          seg_i;
    logic [NDIG-1:0]     an_i;
    logic                clear_i;
    logic [4*NDIG-1:0]   value_o;
    logic [NDIG-1:0]     digit_valid_o;
    logic [NDIG-1:0]     blank_o;
    logic                frame_valid_o;
    logic                err_o;

    modport master (
        output sample_i, seg_i, an_i, clear_i,
        input  value_o, digit_valid_o, blank_o, frame_valid_o, err_o
    );

    modport slave (
        input  sample_i, seg_i, an_i, clear_i,
        output value_o, digit_valid_o, blank_o, frame_valid_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/module_disp_enc.sv
// module_disp_enc: glitch-filtered seven-segment monitor that re-encodes digit patterns to hex.
// Optional macro DISP_ENC_BLANK_EN: accept the all-off pattern as a blank digit. Rev 1.0
`default_nettype none

module module_disp_enc #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    module_disp_enc_if.slave   bus
);
    localparam int CW    = $clog2(STABLE + 1);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

    logic [NDIG-1:0]    prev_an;
    logic [6:0]         prev_seg;
    logic [CW-1:0]      cnt;
    logic [4*NDIG-1:0]  value_q;
    logic [NDIG-1:0]    valid_q;
    logic               frame_q;
    logic               err_q;

    logic               one_hot;
    logic               match;
    logic [CW-1:0]      cnt_nx;
    logic               capture;
    logic [IDX_W-1:0]   idx;
    logic               dec_ok;
    logic [3:0]         dec_nib;
    logic [3:0]         old_nib;
    logic [NDIG-1:0]    valid_nx;
    logic               frame_hit;
`ifdef DISP_ENC_BLANK_EN
    logic [NDIG-1:0]    blank_q;
    logic               dec_blank;
`endif

    always_comb begin
        one_hot = (bus.an_i != '0) && ((bus.an_i & (bus.an_i - NDIG'(1))) == '0);
        match   = (bus.an_i == prev_an) && (bus.seg_i == prev_seg);

        cnt_nx = cnt;
        if (!one_hot)
            cnt_nx = '0;
        else if (!match)
            cnt_nx = CW'(1);
        else if (cnt < STABLE_C)
            cnt_nx = cnt + CW'(1);

        // A fresh pair reaching STABLE in one step only happens for STABLE=1.
        capture = one_hot && (cnt_nx == STABLE_C) && ((cnt != STABLE_C) || !match);

        idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (bus.an_i[i])
                idx = IDX_W'(i);
        end

        dec_ok  = 1'b1;
        dec_nib = 4'h0;
`ifdef DISP_ENC_BLANK_EN
        dec_blank = (bus.seg_i == 7'h00);
`endif
        case (bus.seg_i)
            7'h7E: dec_nib = 4'h0;
            7'h30: dec_nib = 4'h1;
            7'h6D: dec_nib = 4'h2;
            7'h79: dec_nib = 4'h3;
            7'h33: dec_nib = 4'h4;
            7'h5B: dec_nib = 4'h5;
            7'h5F: dec_nib = 4'h6;
            7'h70: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h7B: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h1F: dec_nib = 4'hB;
            7'h4E: dec_nib = 4'hC;
            7'h3D: dec_nib = 4'hD;
            7'h4F: dec_nib = 4'hE;
            7'h47: dec_nib = 4'hF;
`ifdef DISP_ENC_BLANK_EN
            7'h00: dec_nib = 4'h0;
`endif
            default: dec_ok = 1'b0;
        endcase

        old_nib       = value_q[{idx, 2'b00} +: 4];
        valid_nx      = valid_q;
        valid_nx[idx] = dec_ok;
        frame_hit     = (&valid_nx) && (!(&valid_q) || (dec_nib != old_nib));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_an  <= '0;
            prev_seg <= '0;
            cnt      <= '0;
            value_q  <= '0;
            valid_q  <= '0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef DISP_ENC_BLANK_EN
            blank_q  <= '0;
`endif
        end else begin
            frame_q <= 1'b0;
            if (bus.clear_i) begin
                valid_q <= '0;
                err_q   <= 1'b0;
                cnt     <= '0;
                prev_an <= '0;
`ifdef DISP_ENC_BLANK_EN
                blank_q <= '0;
`endif
            end else if (bus.sample_i) begin
                cnt <= cnt_nx;
                if (!one_hot) begin
                    prev_an <= '0;
                end else if (!match) begin
                    prev_an  <= bus.an_i;
                    prev_seg <= bus.seg_i;
                end
                if (capture) begin
                    if (dec_ok) begin
                        value_q[{idx, 2'b00} +: 4] <= dec_nib;
                        valid_q[idx]               <= 1'b1;
                        frame_q                    <= frame_hit;
`ifdef DISP_ENC_BLANK_EN
                        blank_q[idx]               <= dec_blank;
`endif
                    end else begin
                        err_q        <= 1'b1;
                        valid_q[idx] <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.value_o       = value_q;
    assign bus.digit_valid_o = valid_q;
    assign bus.frame_valid_o = frame_q;
    assign bus.err_o         = err_q;
`ifdef DISP_ENC_BLANK_EN
    assign bus.blank_o       = blank_q;
`else
    assign bus.blank_o       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_module_disp_enc.sv
// tb_module_disp_enc: directed table-driven checks of the segment monitor (NDIG=4, STABLE=3).
`default_nettype none

module tb_module_disp_enc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   fv_count = 0;
    int   fv_base;

    module_disp_enc_if #(.NDIG(4)) bus ();

    module_disp_enc #(.NDIG(4), .STABLE(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_valid_o === 1'b1)
            fv_count++;
    end

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          reps;
        logic [15:0] value;
        logic [3:0]  valid;
        logic        err;
        int          fv;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [15:0] value, input logic [3:0] valid,
                             input logic [3:0] blank, input logic err, input int fv);
        #1;
        chk({name, ".value"}, 32'(bus.value_o), 32'(value));
        chk({name, ".valid"}, 32'(bus.digit_valid_o), 32'(valid));
        chk({name, ".blank"}, 32'(bus.blank_o), 32'(blank));
        chk({name, ".err"}, 32'(bus.err_o), 32'(err));
        chk({name, ".frames"}, 32'(fv_count - fv_base), 32'(fv));
    endtask

    // Drive one (an, seg) pair for n strobed cycles; returns at a falling edge.
    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        for (int i = 0; i < n; i++) begin
            bus.an_i     = an;
            bus.seg_i    = seg;
            bus.sample_i = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        tbl[0]  = '{4'b0001, 7'h5B, 3, 16'h0005, 4'b0001, 1'b0, 0};
        tbl[1]  = '{4'b0010, 7'h30, 3, 16'h0015, 4'b0011, 1'b0, 0};
        tbl[2]  = '{4'b0100, 7'h6D, 3, 16'h0215, 4'b0111, 1'b0, 0};
        tbl[3]  = '{4'b1000, 7'h79, 3, 16'h3215, 4'b1111, 1'b0, 1};
        tbl[4]  = '{4'b0001, 7'h7E, 3, 16'h3210, 4'b1111, 1'b0, 2};
        tbl[5]  = '{4'b0010, 7'h30, 3, 16'h3210, 4'b1111, 1'b0, 2};
        tbl[6]  = '{4'b0100, 7'h7F, 3, 16'h3810, 4'b1111, 1'b0, 3};
        tbl[7]  = '{4'b0001, 7'h7F, 2, 16'h3810, 4'b1111, 1'b0, 3};
        tbl[8]  = '{4'b0001, 7'h7B, 3, 16'h3819, 4'b1111, 1'b0, 4};
        tbl[9]  = '{4'b0010, 7'h6D, 2, 16'h3819, 4'b1111, 1'b0, 4};
        tbl[10] = '{4'b0011, 7'h6D, 1, 16'h3819, 4'b1111, 1'b0, 4};
        tbl[11] = '{4'b0010, 7'h6D, 2, 16'h3819, 4'b1111, 1'b0, 4};
        tbl[12] = '{4'b0010, 7'h6D, 1, 16'h3829, 4'b1111, 1'b0, 5};
        tbl[13] = '{4'b0000, 7'h6D, 1, 16'h3829, 4'b1111, 1'b0, 5};
        tbl[14] = '{4'b0010, 7'h01, 3, 16'h3829, 4'b1101, 1'b1, 5};
        tbl[15] = '{4'b0010, 7'h30, 3, 16'h3819, 4'b1111, 1'b1, 6};
        tbl[16] = '{4'b0010, 7'h30, 4, 16'h3819, 4'b1111, 1'b1, 6};

        bus.sample_i = 1'b1;
        bus.clear_i  = 1'b0;
        bus.an_i     = '0;
        bus.seg_i    = '0;
        fv_base      = 0;

        // Reset held while the bus toggles randomly.
        for (int i = 0; i < 4; i++) begin
            bus.an_i  = 4'($urandom);
            bus.seg_i = 7'($urandom);
            @(negedge clk);
        end
        check_all("reset", 16'h0, 4'h0, 4'h0, 1'b0, 0);
        rst_n = 1'b1;

        drive(4'b0001, 7'h30, 2);
        check_all("post_rst_2", 16'h0, 4'h0, 4'h0, 1'b0, 0);
        drive(4'b0001, 7'h30, 1);
        check_all("post_rst_3", 16'h0001, 4'b0001, 4'h0, 1'b0, 0);

        // Asynchronous reset in the middle of an episode.
        drive(4'b0010, 7'h6D, 2);
        #2 rst_n = 1'b0;
        check_all("mid_rst", 16'h0, 4'h0, 4'h0, 1'b0, 0);
        rst_n = 1'b1;
        drive(4'b0010, 7'h6D, 2);
        check_all("after_rst_2", 16'h0, 4'h0, 4'h0, 1'b0, 0);
        drive(4'b0010, 7'h6D, 1);
        check_all("after_rst_3", 16'h0020, 4'b0010, 4'h0, 1'b0, 0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 fv_base = fv_count;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].an, tbl[i].seg, tbl[i].reps);
            check_all($sformatf("vec%0d", i), tbl[i].value, tbl[i].valid, 4'h0, tbl[i].err, tbl[i].fv);
        end

        // Clear on the capture cycle wins and restarts filtering.
        drive(4'b0100, 7'h4E, 2);
        bus.clear_i = 1'b1;
        drive(4'b0100, 7'h4E, 1);
        bus.clear_i = 1'b0;
        check_all("clr_capture", 16'h3819, 4'b0000, 4'h0, 1'b0, 6);
        drive(4'b0100, 7'h4E, 2);
        check_all("clr_refilter", 16'h3819, 4'b0000, 4'h0, 1'b0, 6);
        drive(4'b0100, 7'h4E, 1);
        check_all("clr_recapture", 16'h3C19, 4'b0100, 4'h0, 1'b0, 6);

        drive(4'b1000, 7'h00, 3);
`ifdef DISP_ENC_BLANK_EN
        check_all("blank", 16'h0C19, 4'b1100, 4'b1000, 1'b0, 6);
`else
        check_all("blank", 16'h3C19, 4'b0100, 4'b0000, 1'b1, 6);
`endif

        // With the strobe low nothing moves.
        bus.sample_i = 1'b0;
        bus.an_i     = 4'b0001;
        bus.seg_i    = 7'h7E;
        repeat (5) @(negedge clk);
`ifdef DISP_ENC_BLANK_EN
        check_all("no_strobe", 16'h0C19, 4'b1100, 4'b1000, 1'b0, 6);
`else
        check_all("no_strobe", 16'h3C19, 4'b0100, 4'b0000, 1'b1, 6);
`endif

        bus.clear_i = 1'b1;
        drive(4'b0000, 7'h00, 1);
        bus.clear_i = 1'b0;
`ifdef DISP_ENC_BLANK_EN
        check_all("clear", 16'h0C19, 4'h0, 4'h0, 1'b0, 6);
`else
        check_all("clear", 16'h3C19, 4'h0, 4'h0, 1'b0, 6);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/module_disp_enc.md
# module_disp_enc

Seven-segment display monitor: samples a multiplexed segment bus (`seg_i` plus one-hot digit enables `an_i`), filters glitches, and encodes each digit's pattern back into a hex nibble. It is the inverse of `module_disp_dec`, using the same segment table and bit order. It sits on the display outputs for loopback self-test and board-level checking of the display path. It flags undecodable patterns and signals when a complete, valid multi-digit value has been reconstructed.

## Interface
- `NDIG`, default 4: number of multiplexed digits; must be at least 1.
- `STABLE`, default 3: number of consecutive identical samples required before a capture; must be at least 1.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample_i` in 1: sample strobe; the bus is evaluated only in cycles where this is high.
- `seg_i` in 7: segment lines, active-high, `[6]`=a through `[0]`=g.
- `an_i` in NDIG: digit enables, active-high; a legal value is one-hot.
- `clear_i` in 1: synchronous clear of the valid, error, blank and filter state.
- `value_o` out 4*NDIG: captured nibbles; digit k occupies `[4k+3:4k]`.
- `digit_valid_o` out NDIG: digit k holds a valid decoded nibble.
- `blank_o` out NDIG: digit k was captured as blank (see Configuration).
- `frame_valid_o` out 1: single-cycle pulse when a complete valid frame is available.
- `err_o` out 1: sticky flag for an undecodable stable pattern.

## Operation
- Filter state:
  - `prev_an` (NDIG bits), `prev_seg` (7 bits).
  - Counter `cnt`, width $clog2(STABLE+1), saturating at STABLE.
- In each cycle where `sample_i`=1, the block applies the following rules.
  - `an_i` not one-hot (zero or more than one bit set): treat as a blanking interval. Set `cnt`=0, clear `prev_an`, do not capture.
  - (`an_i`,`seg_i`) differs from (`prev_an`,`prev_seg`): load the new pair into `prev_an`/`prev_seg` and set `cnt`=1.
  - The pair matches and `cnt`<STABLE: increment `cnt`.
  - In every case, if the updated `cnt` equals STABLE and the previous `cnt` did not, perform a capture for digit k = index of `an_i`. This gives exactly one capture per stable episode; further matching samples do nothing. When STABLE=1, the first sample of a new pair captures.
- Capture decode table (pattern -> nibble):
  - 7E->0, 30->1, 6D->2, 79->3
  - 33->4, 5B->5, 5F->6, 70->7
  - 7F->8, 7B->9, 77->A, 1F->B
  - 4E->C, 3D->D, 4F->E, 47->F
- Capture result for digit k:
  - Pattern in the table: write the nibble to `value_o[4k+3:4k]`, set `digit_valid_o[k]`, clear `blank_o[k]`.
  - Pattern not in the table: set `err_o`, clear `digit_valid_o[k]`, leave the nibble unchanged.
- `frame_valid_o` pulses when a capture leaves `digit_valid_o` all ones and either:
  - `digit_valid_o` was not all ones before the capture, or
  - the captured nibble differs from the value it replaced.
- `clear_i`=1:
  - Clears `digit_valid_o`, `blank_o`, `err_o`, `cnt` and `prev_an`.
  - Has priority over a same-cycle capture, which is discarded.
  - Does not clear `value_o`.
- When `sample_i`=0, all state holds.

## Timing
- Reset values: `value_o`=0, `digit_valid_o`=0, `blank_o`=0, `frame_valid_o`=0, `err_o`=0, `cnt`=0, `prev_an`=0, `prev_seg`=0.
- All outputs are registered. A capture triggered by the sample at edge N is visible after edge N, in the same cycle as its `frame_valid_o` pulse.
- `frame_valid_o` is high for exactly one cycle per qualifying capture.
- Minimum capture latency is STABLE strobed cycles from the first sample of a new pair.
- Reset asserted mid-episode drops all filter progress immediately. After release, a full STABLE run is required before the next capture.
- No combinational path exists from any input to any output.

## Configuration
- Macro: `DISP_ENC_BLANK_EN`.
- Defined:
  - A stable all-off pattern (0x00) is legal.
  - Capture writes nibble 0 and sets `digit_valid_o[k]` and `blank_o[k]`.
  - No error is raised.
- Undefined:
  - 0x00 is undecodable and sets `err_o`.
  - `blank_o` is tied to 0 and the port remains present.

## Test plan
- Reset: hold `rst_n`=0 while driving random bus values -> all outputs 0; after release, no capture before STABLE strobed samples.
- Single digit: `an_i`=0001, `seg_i`=0x5B, three strobes (STABLE=3) -> `value_o[3:0]`=5 and `digit_valid_o`=0001 after the third edge; `frame_valid_o` stays 0.
- Full frame: digits 0..3 driven stable with 0x7E, 0x30, 0x6D, 0x79 -> `value_o`=0x3210, `digit_valid_o`=1111, exactly one `frame_valid_o` pulse. Re-scanning the same patterns produces no further pulse; changing digit 2 to 0x7F produces one pulse and `value_o`=0x3810.
- Glitch rejection: on digit 0, sequence 0x7F, 0x7F, 0x7B, 0x7B, 0x7B -> captures 9, never 8. `an_i`=0011 or 0000 mid-run -> `cnt` resets and no capture occurs.
- Error and clear: stable 0x01 on digit 1 -> `err_o`=1 and `digit_valid_o[1]`=0. `clear_i` asserted on the cycle of a capture -> capture discarded and `err_o`=0.
- Blank: stable 0x00 on digit 3 -> with `DISP_ENC_BLANK_EN`, `blank_o[3]`=1, `digit_valid_o[3]`=1, nibble 0; without the macro, `err_o`=1.
